color_classifier_avg: RTL and testbench



---
 rtl/color_classifier_avg_if.sv | 25 ++
 rtl/color_classifier_avg.sv | 150 +++++++++++++++
 tb/tb_color_classifier_avg.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/color_classifier_avg_if.sv
// Sample/result bundle between the colour-sensor front end and the classifier.
// master drives samples and flush; slave (the classifier) returns results.
interface color_classifier_avg_if #(
   parameter int CW = 8
);
   logic          sample_valid;
   logic [CW-1:0] red;
   logic [CW-1:0] green;
   logic [CW-1:0] blue;
   logic          flush;
   logic          color_valid;
   logic [2:0]    color;
   logic          color_stable;
   logic [3:0]    run_len;

   modport master (
      output sample_valid, red, green, blue, flush,
      input  color_valid, color, color_stable, run_len
   );

   modport slave (
      input  sample_valid, red, green, blue, flush,
      output color_valid, color, color_stable, run_len
   );
endinterface

// File: rtl/color_classifier_avg.sv
// Windowed RGB averager + six-colour classifier with agreement tracking.
// Define COLOR_CLASSIFIER_UNKNOWN_EN to report dark windows as UNKNOWN (6).
module color_classifier_avg #(
   parameter int CW          = 8,
   parameter int AVG_LOG2    = 2,
   parameter int STABLE_CNT  = 3,
   parameter int THR_RED_HI  = 7,
   parameter int THR_BLUE_W  = 4,
   parameter int THR_GREEN_Y = 6,
   parameter int THR_RED_R   = 5,
   parameter int THR_GREEN_B = 5,
   parameter int THR_DARK    = 2
) (
   input logic                  clock,
   input logic                  reset_n,
   color_classifier_avg_if.slave bus
);
   localparam int AW   = CW + AVG_LOG2;
   localparam int CNTW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
   localparam logic [CNTW-1:0] LAST = CNTW'((1 << AVG_LOG2) - 1);
   localparam logic [3:0] SC = 4'(STABLE_CNT);

   localparam logic [CW-1:0] T_RHI = CW'(THR_RED_HI);
   localparam logic [CW-1:0] T_BW  = CW'(THR_BLUE_W);
   localparam logic [CW-1:0] T_GY  = CW'(THR_GREEN_Y);
   localparam logic [CW-1:0] T_RR  = CW'(THR_RED_R);
   localparam logic [CW-1:0] T_GB  = CW'(THR_GREEN_B);
   localparam logic [CW-1:0] T_DK  = CW'(THR_DARK);

   localparam logic [2:0] C_W   = 3'd0;
   localparam logic [2:0] C_O   = 3'd1;
   localparam logic [2:0] C_G   = 3'd2;
   localparam logic [2:0] C_R   = 3'd3;
   localparam logic [2:0] C_B   = 3'd4;
   localparam logic [2:0] C_Y   = 3'd5;
   localparam logic [2:0] C_UNK = 3'd6;

`ifdef COLOR_CLASSIFIER_UNKNOWN_EN
   localparam bit UNK_EN = 1'b1;
`else
   localparam bit UNK_EN = 1'b0;
`endif

   logic [AW-1:0]   acc_r_q, acc_g_q, acc_b_q;
   logic [AW-1:0]   acc_r_d, acc_g_d, acc_b_d;
   logic [AW-1:0]   sum_r, sum_g, sum_b;
   logic [CNTW-1:0] cnt_q, cnt_d;
   logic            close;
   logic            close_q;
   logic [CW-1:0]   avg_r_q, avg_g_q, avg_b_q;
   logic [2:0]      cls;
   logic            dark;
   logic [2:0]      color_q, color_d;
   logic [3:0]      run_q, run_d;
   logic            stable_q, stable_d;
   logic            valid_q;

   assign sum_r = acc_r_q + AW'(bus.red);
   assign sum_g = acc_g_q + AW'(bus.green);
   assign sum_b = acc_b_q + AW'(bus.blue);
   assign close = bus.sample_valid && !bus.flush && (cnt_q == LAST);

   always_comb begin
      acc_r_d = acc_r_q;
      acc_g_d = acc_g_q;
      acc_b_d = acc_b_q;
      cnt_d   = cnt_q;
      if (bus.flush || close) begin
         acc_r_d = '0;
         acc_g_d = '0;
         acc_b_d = '0;
         cnt_d   = '0;
      end else if (bus.sample_valid) begin
         acc_r_d = sum_r;
         acc_g_d = sum_g;
         acc_b_d = sum_b;
         cnt_d   = cnt_q + 1'b1;
      end
   end

   // Priority tree: the bright-red group is decided before R/G/B.
   always_comb begin
      cls = C_G;
      if (avg_r_q >= T_RHI) begin
         if (avg_b_q >= T_BW)      cls = C_W;
         else if (avg_g_q >= T_GY) cls = C_Y;
         else                      cls = C_O;
      end else if (avg_r_q >= T_RR) begin
         cls = C_R;
      end else if (avg_b_q > avg_g_q && avg_g_q < T_GB) begin
         cls = C_B;
      end
      dark = UNK_EN && (avg_r_q < T_DK) && (avg_g_q < T_DK)
                    && (avg_b_q < T_DK);
      if (dark) cls = C_UNK;
   end

   always_comb begin
      color_d  = color_q;
      run_d    = run_q;
      stable_d = stable_q;
      if (close_q) begin
         color_d = cls;
         if (dark)
            run_d = 4'd0;
         else if (cls == color_q && run_q != 4'd0)
            run_d = (run_q >= SC) ? SC : run_q + 4'd1;
         else
            run_d = 4'd1;
         stable_d = (run_d == SC);
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         acc_r_q  <= '0;
         acc_g_q  <= '0;
         acc_b_q  <= '0;
         cnt_q    <= '0;
         close_q  <= 1'b0;
         avg_r_q  <= '0;
         avg_g_q  <= '0;
         avg_b_q  <= '0;
         color_q  <= C_W;
         run_q    <= 4'd0;
         stable_q <= 1'b0;
         valid_q  <= 1'b0;
      end else begin
         acc_r_q  <= acc_r_d;
         acc_g_q  <= acc_g_d;
         acc_b_q  <= acc_b_d;
         cnt_q    <= cnt_d;
         close_q  <= close;
         if (close) begin
            avg_r_q <= CW'(sum_r >> AVG_LOG2);
            avg_g_q <= CW'(sum_g >> AVG_LOG2);
            avg_b_q <= CW'(sum_b >> AVG_LOG2);
         end
         color_q  <= color_d;
         run_q    <= run_d;
         stable_q <= stable_d;
         valid_q  <= close_q;
      end
   end

   assign bus.color_valid  = valid_q;
   assign bus.color        = color_q;
   assign bus.run_len      = run_q;
   assign bus.color_stable = stable_q;
endmodule

// File: tb/tb_color_classifier_avg.sv
// Directed bench for color_classifier_avg at default parameters.
// Result pulses are logged on the falling edge and checked afterwards.
module tb_color_classifier_avg;
   logic clock = 1'b0;
   logic reset_n = 1'b0;
   int   n_asrt = 0;
   int   n_fail = 0;
   int   vcount = 0;
   int   base;

   logic [2:0] lc[64];
   logic [3:0] lr[64];
   logic       ls[64];

   int ec[5] = '{0, 0, 0, 0, 5};
   int er[5] = '{1, 2, 3, 3, 1};
   int es[5] = '{0, 0, 1, 1, 0};

   color_classifier_avg_if #(.CW(8)) bus ();

   color_classifier_avg u_dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clock = ~clock;

   always @(negedge clock) begin
      if (bus.color_valid === 1'b1) begin
         if (vcount < 64) begin
            lc[vcount] = bus.color;
            lr[vcount] = bus.run_len;
            ls[vcount] = bus.color_stable;
         end
         vcount++;
      end
   end

   task automatic chk(input string tag, input logic [7:0] got,
                      input logic [7:0] exp);
      n_asrt++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic smp(input logic [7:0] r, input logic [7:0] g,
                      input logic [7:0] b);
      bus.sample_valid = 1'b1;
      bus.red   = r;
      bus.green = g;
      bus.blue  = b;
      @(posedge clock);
      #1;
      bus.sample_valid = 1'b0;
   endtask

   initial begin
      bus.sample_valid = 1'b0;
      bus.red   = '0;
      bus.green = '0;
      bus.blue  = '0;
      bus.flush = 1'b0;

      // reset state
      idle(2);
      chk("rst_color", 8'(bus.color), 8'd0);
      chk("rst_valid", 8'(bus.color_valid), 8'd0);
      chk("rst_run", 8'(bus.run_len), 8'd0);
      chk("rst_stable", 8'(bus.color_stable), 8'd0);
      reset_n = 1'b1;
      idle(1);

      // orange window and latency
      repeat (4) smp(8'd8, 8'd1, 8'd1);
      chk("o_early", 8'(bus.color_valid), 8'd0);
      idle(1);
      chk("o_valid", 8'(bus.color_valid), 8'd1);
      chk("o_color", 8'(bus.color), 8'd1);
      chk("o_run", 8'(bus.run_len), 8'd1);
      chk("o_stable", 8'(bus.color_stable), 8'd0);
      idle(1);
      chk("o_pulse", 8'(bus.color_valid), 8'd0);
      chk("o_hold", 8'(bus.color), 8'd1);

      // truncating average lands on Red
      repeat (3) smp(8'd7, 8'd1, 8'd1);
      smp(8'd6, 8'd1, 8'd1);
      idle(1);
      chk("trunc_color", 8'(bus.color), 8'd3);
      chk("trunc_run", 8'(bus.run_len), 8'd1);

      // back-to-back W windows, saturation, then Y
      idle(1);
      base = vcount;
      repeat (16) smp(8'd9, 8'd9, 8'd9);
      repeat (4) smp(8'd9, 8'd7, 8'd1);
      idle(2);
      chk("b2b_count", 8'(vcount - base), 8'd5);
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("b2b%0d_color", i), 8'(lc[base+i]), 8'(ec[i]));
         chk($sformatf("b2b%0d_run", i), 8'(lr[base+i]), 8'(er[i]));
         chk($sformatf("b2b%0d_stable", i), 8'(ls[base+i]), 8'(es[i]));
      end

      // flush with a simultaneous sample, then a Blue window
      base = vcount;
      repeat (2) smp(8'd9, 8'd9, 8'd9);
      bus.flush = 1'b1;
      smp(8'd9, 8'd9, 8'd9);
      bus.flush = 1'b0;
      chk("fl_keep_color", 8'(bus.color), 8'd5);
      chk("fl_keep_run", 8'(bus.run_len), 8'd1);
      repeat (4) smp(8'd2, 8'd3, 8'd8);
      idle(2);
      chk("fl_count", 8'(vcount - base), 8'd1);
      chk("fl_color", 8'(bus.color), 8'd4);
      chk("fl_run", 8'(bus.run_len), 8'd1);

      // reset mid-window, then a Green window
      repeat (3) smp(8'd8, 8'd8, 8'd8);
      reset_n = 1'b0;
      idle(1);
      reset_n = 1'b1;
      chk("mrst_color", 8'(bus.color), 8'd0);
      chk("mrst_run", 8'(bus.run_len), 8'd0);
      base = vcount;
      repeat (4) smp(8'd1, 8'd9, 8'd2);
      idle(2);
      chk("mrst_count", 8'(vcount - base), 8'd1);
      chk("mrst_gcolor", 8'(bus.color), 8'd2);
      chk("mrst_grun", 8'(bus.run_len), 8'd1);

      // dark window
      repeat (4) smp(8'd1, 8'd1, 8'd1);
      idle(2);
`ifdef COLOR_CLASSIFIER_UNKNOWN_EN
      chk("dark_color", 8'(bus.color), 8'd6);
      chk("dark_run", 8'(bus.run_len), 8'd0);
`else
      chk("dark_color", 8'(bus.color), 8'd2);
      chk("dark_run", 8'(bus.run_len), 8'd2);
`endif
      chk("dark_stable", 8'(bus.color_stable), 8'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_asrt, n_fail);
      $finish;
   end
endmodule
